// File: rtl/mips_defs_pkg.sv
// rtl/mips_defs_pkg.sv - shared MIPS opcode/funct constants, FSM states and ALU helpers
//
// Purpose: definitions shared by the single-cycle and multi-cycle MIPS cores.
// Contents: opcode and funct field values, multi-cycle FSM state encoding,
//           ALU operation codes and the ALU itself as a pure function.
package mips_defs;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] F_ADD = 6'd32;
  localparam logic [5:0] F_SUB = 6'd34;
  localparam logic [5:0] F_AND = 6'd36;
  localparam logic [5:0] F_OR  = 6'd37;
  localparam logic [5:0] F_SLT = 6'd42;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_t;

  function automatic logic legal_funct(logic [5:0] f);
    return f inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT};
  endfunction

  function automatic alu_op_t funct_to_alu_op(logic [5:0] f);
    case (f)
      F_SUB:   return ALU_SUB;
      F_AND:   return ALU_AND;
      F_OR:    return ALU_OR;
      F_SLT:   return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

  // 32-bit wrapping arithmetic, slt compares as signed.
  function automatic logic [31:0] alu(alu_op_t op, logic [31:0] x, logic [31:0] y);
    case (op)
      ALU_SUB: return x - y;
      ALU_AND: return x & y;
      ALU_OR:  return x | y;
      ALU_SLT: return {31'd0, $signed(x) < $signed(y)};
      default: return x + y;
    endcase
  endfunction

endpackage

// File: rtl/mips_multicycle_regfile.sv
// rtl/mips_multicycle_regfile.sv - MIPS register file, 2 async reads, 1 sync write
//
// Purpose: NREGS x 32-bit architectural registers; R0 always reads zero.
// Ports:
//   clk, reset          clock, synchronous active-low reset (clears every register)
//   raddr1/raddr2       read addresses; rdata1/rdata2 combinational read data
//   we, waddr, wdata    write port, applied at the rising edge; writes to R0 dropped
module mips_regfile #(
  parameter int NREGS = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [$clog2(NREGS)-1:0] raddr1,
  input  logic [$clog2(NREGS)-1:0] raddr2,
  input  logic                     we,
  input  logic [$clog2(NREGS)-1:0] waddr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata1,
  output logic [31:0]              rdata2
);

  logic [31:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

endmodule

// File: rtl/mips_multicycle.sv
// rtl/mips_multicycle.sv - multi-cycle MIPS core with one shared req/ready memory port
//
// Purpose: executes add/sub/and/or/slt, addi, lw, sw, beq, j through a
//   FETCH -> DECODE -> EXEC -> MEM -> WB state machine; illegal opcodes,
//   out-of-range register fields and misaligned data addresses enter HALT.
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   mem_req/mem_we        request strobe and write select, held until mem_ready
//   mem_addr/mem_wdata    word-aligned byte address and store data
//   mem_ready/mem_rdata   completion strobe and read data from memory
//   address/instruction   debug view of PC and instruction register
//   result                last writeback value
//   retire                one-cycle pulse per completed instruction
//   halted                sticky fault indication
module mips_multicycle
  import mips_defs::*;
#(
  parameter int                ADDR_W   = 16,
  parameter int                NREGS    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] address,
  output logic [31:0]       instruction,
  output logic [31:0]       result,
  output logic              retire,
  output logic              halted
);

  localparam int RW = $clog2(NREGS);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] target;
  logic [31:0]       ir;
  logic [31:0]       a;
  logic [31:0]       b;
  logic [31:0]       alu_out;
  logic [31:0]       mdr;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [31:0] simm;

  assign opcode = ir[31:26];
  assign rs     = ir[25:21];
  assign rt     = ir[20:16];
  assign rd     = ir[15:11];
  assign funct  = ir[5:0];
  assign simm   = {{16{ir[15]}}, ir[15:0]};

  logic [31:0] rf_rdata1;
  logic [31:0] rf_rdata2;
  logic [4:0]  wb_dest;
  logic [31:0] wb_value;

  // True when a 5-bit register field names a register this core does not have.
  function automatic logic reg_bad(logic [4:0] idx);
    return (idx >> RW) != 5'd0;
  endfunction

  logic        legal;
  alu_op_t     alu_op;
  logic [31:0] alu_b;
  logic [31:0] alu_res;

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_RTYPE:                    legal = legal_funct(funct) && !reg_bad(rs) && !reg_bad(rt) && !reg_bad(rd);
      OP_ADDI, OP_LW, OP_SW, OP_BEQ: legal = !reg_bad(rs) && !reg_bad(rt);
      OP_J:                        legal = 1'b1;
      default:                     legal = 1'b0;
    endcase
    alu_op   = (opcode == OP_RTYPE) ? funct_to_alu_op(funct) : ALU_ADD;
    alu_b    = (opcode == OP_RTYPE) ? b : simm;
    alu_res  = alu(alu_op, a, alu_b);
    wb_dest  = (opcode == OP_RTYPE) ? rd : rt;
    wb_value = (opcode == OP_LW) ? mdr : alu_out;
  end

  // Jump keeps the PC bits above the 28-bit region only when the PC has them.
  logic [ADDR_W-1:0] jump_pc;
  if (ADDR_W > 28) begin : g_jump_hi
    assign jump_pc = {pc[ADDR_W-1:28], ir[25:0], 2'b00};
  end else begin : g_jump_lo
    assign jump_pc = ADDR_W'({ir[25:0], 2'b00});
  end

  mips_regfile #(.NREGS(NREGS)) u_rf (
    .clk    (clk),
    .reset  (reset),
    .raddr1 (rs[RW-1:0]),
    .raddr2 (rt[RW-1:0]),
    .we     (state == ST_WB),
    .waddr  (wb_dest[RW-1:0]),
    .wdata  (wb_value),
    .rdata1 (rf_rdata1),
    .rdata2 (rf_rdata2)
  );

  // The request is decoded from the state so it is already up in the first
  // FETCH/MEM cycle; gating with reset drops it as soon as reset is applied,
  // since the state register itself only clears at the next edge.
  assign mem_req   = reset && (state == ST_FETCH || state == ST_MEM);
  assign mem_we    = reset && (state == ST_MEM) && (opcode == OP_SW);
  assign mem_addr  = (state == ST_MEM) ? alu_out[ADDR_W-1:0] : pc;
  assign mem_wdata = b;

  assign address     = pc;
  assign instruction = ir;
  assign halted      = (state == ST_HALT);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= ST_FETCH;
      pc      <= RESET_PC;
      target  <= '0;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
      mdr     <= '0;
      result  <= '0;
      retire  <= 1'b0;
    end else begin
      retire <= 1'b0;
      case (state)
        ST_FETCH: begin
          if (mem_ready) begin
            ir    <= mem_rdata;
            pc    <= pc + ADDR_W'(4);
            state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          a      <= rf_rdata1;
          b      <= rf_rdata2;
          target <= pc + ADDR_W'({simm[29:0], 2'b00});
          state  <= legal ? ST_EXEC : ST_HALT;
        end
        ST_EXEC: begin
          case (opcode)
            OP_LW, OP_SW: begin
              alu_out <= alu_res;
              // A misaligned effective address faults before any access is made.
              state   <= (alu_res[1:0] != 2'b00) ? ST_HALT : ST_MEM;
            end
            OP_BEQ: begin
              if (a == b) pc <= target;
              retire <= 1'b1;
              state  <= ST_FETCH;
            end
            OP_J: begin
              pc     <= jump_pc;
              retire <= 1'b1;
              state  <= ST_FETCH;
            end
            default: begin
              alu_out <= alu_res;
              state   <= ST_WB;
            end
          endcase
        end
        ST_MEM: begin
          if (mem_ready) begin
            if (opcode == OP_SW) begin
              retire <= 1'b1;
              state  <= ST_FETCH;
            end else begin
              mdr   <= mem_rdata;
              state <= ST_WB;
            end
          end
        end
        ST_WB: begin
          result <= wb_value;
          retire <= 1'b1;
          state  <= ST_FETCH;
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle.sv
// tb/tb_mips_multicycle.sv - directed self-checking bench for mips_multicycle
module tb_mips_multicycle;

  localparam int ADDR_W = 16;

  localparam logic [5:0] C_ADDI = 6'd8;
  localparam logic [5:0] C_LW   = 6'd35;
  localparam logic [5:0] C_SW   = 6'd43;
  localparam logic [5:0] C_BEQ  = 6'd4;
  localparam logic [5:0] C_ADD  = 6'd32;
  localparam logic [5:0] C_SUB  = 6'd34;
  localparam logic [5:0] C_AND  = 6'd36;
  localparam logic [5:0] C_OR   = 6'd37;
  localparam logic [5:0] C_SLT  = 6'd42;
  localparam logic [31:0] NOP   = 32'h0000_0020;

  logic              clk = 1'b0;
  logic              reset;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;
  logic [31:0]       mem_rdata;
  logic [ADDR_W-1:0] address;
  logic [31:0]       instruction;
  logic [31:0]       result;
  logic              retire;
  logic              halted;

  always #5 clk = ~clk;

  mips_multicycle #(.ADDR_W(ADDR_W), .NREGS(32), .RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
    .address     (address),
    .instruction (instruction),
    .result      (result),
    .retire      (retire),
    .halted      (halted)
  );

  // Memory model: ready after wait_cycles stalled cycles of a request.
  logic [31:0] mem [1024];
  int          wait_cycles = 0;
  int          req_cnt = 0;
  logic        prog_we = 1'b0;
  logic [9:0]  prog_idx = '0;
  logic [31:0] prog_data = '0;

  assign mem_ready = mem_req && (req_cnt >= wait_cycles);
  assign mem_rdata = mem[mem_addr[11:2]];

  always @(posedge clk) begin
    if (prog_we) mem[prog_idx] <= prog_data;
    else if (mem_req && mem_ready && mem_we) mem[mem_addr[11:2]] <= mem_wdata;
    if (mem_req && !mem_ready) req_cnt <= req_cnt + 1;
    else req_cnt <= 0;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int byte_addr, input logic [31:0] w);
    prog_we   = 1'b1;
    prog_idx  = 10'(byte_addr >> 2);
    prog_data = w;
    step();
    prog_we = 1'b0;
  endtask

  task automatic wait_retire(output int lat);
    lat = 0;
    do begin
      step();
      lat++;
    end while (!retire && lat < 100);
    if (!retire) check("retire_timeout", 32'(retire), 32'd1);
  endtask

  function automatic logic [31:0] enc_r(int rs, int rt, int rd, logic [5:0] f);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, f};
  endfunction

  function automatic logic [31:0] enc_i(logic [5:0] op, int rs, int rt, int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] enc_j(int tgt);
    return {6'd2, 26'(tgt)};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int          lat;
  logic        seen_req;
  logic [31:0] exp5 [8];

  initial begin
    reset = 1'b0;
    exp5 = '{32'd9, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd1, 32'd1, 32'hFFFF_FFFF, 32'd0};

    // Program for reset, zero-wait and wait-state tests.
    load(0,  enc_i(C_ADDI, 0, 1, 5));
    load(4,  enc_i(C_ADDI, 0, 2, 7));
    load(8,  enc_r(1, 2, 3, C_ADD));
    load(12, enc_i(C_SW, 0, 3, 8));
    load(16, enc_i(C_LW, 0, 4, 8));

    // Reset behaviour, including abandoning a stalled fetch.
    check("rst_req", mem_req, 0);
    check("rst_addr", address, 0);
    check("rst_halted", halted, 0);
    wait_cycles = 1000;
    reset = 1'b1;
    #1;
    check("rel_req", mem_req, 1);
    check("rel_addr", mem_addr, 0);
    check("rel_we", mem_we, 0);
    step();
    step();
    check("stall_req", mem_req, 1);
    reset = 1'b0;
    step();
    check("abandon_req", mem_req, 0);
    step();
    step();
    check("held_req", mem_req, 0);
    check("held_addr", address, 0);
    check("held_halted", halted, 0);

    // Zero-wait: addi, addi, add retire at edges 4, 8, 12.
    wait_cycles = 0;
    reset = 1'b1;
    #1;
    check("go_req", mem_req, 1);
    check("go_addr", mem_addr, 0);
    for (int n = 1; n <= 12; n++) begin
      step();
      check($sformatf("retire_c%0d", n), retire, (n % 4 == 0));
      if (n == 4) check("res_addi1", result, 5);
      if (n == 8) check("res_addi2", result, 7);
    end
    check("res_add", result, 12);

    // Wait states: store request must stay stable for four cycles.
    wait_cycles = 3;
    repeat (6) step();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("sw_req%0d", k), mem_req, 1);
      check($sformatf("sw_we%0d", k), mem_we, 1);
      check($sformatf("sw_addr%0d", k), mem_addr, 8);
      check($sformatf("sw_wdata%0d", k), mem_wdata, 12);
      step();
    end
    check("sw_retire", retire, 1);
    check("sw_mem", mem[2], 12);
    wait_retire(lat);
    check("lw_lat", lat, 11);
    check("lw_res", result, 12);

    // Branches and jump.
    reset = 1'b0;
    wait_cycles = 0;
    load(0,   enc_i(C_ADDI, 0, 1, 5));
    load(4,   enc_i(C_ADDI, 0, 2, 7));
    load(8,   NOP);
    load(12,  NOP);
    load(16,  enc_i(C_BEQ, 1, 1, 2));
    load(20,  enc_i(C_ADDI, 0, 9, 1));
    load(24,  enc_i(C_ADDI, 0, 9, 1));
    load(28,  enc_i(C_BEQ, 1, 2, 5));
    load(32,  enc_j(32'h40));
    load(256, 32'hFC00_0000);
    reset = 1'b1;
    repeat (4) wait_retire(lat);
    wait_retire(lat);
    check("beq_t_lat", lat, 3);
    check("beq_t_next", mem_addr, 16'h001C);
    wait_retire(lat);
    check("beq_nt_next", mem_addr, 16'h0020);
    wait_retire(lat);
    check("j_lat", lat, 3);
    check("j_next", mem_addr, 16'h0100);

    // Illegal opcode 0x3F halts permanently.
    repeat (4) step();
    check("ill_halted", halted, 1);
    check("ill_req", mem_req, 0);
    check("ill_ir", instruction, 32'hFC00_0000);
    repeat (10) step();
    check("ill_halted_late", halted, 1);
    check("ill_req_late", mem_req, 0);
    check("ill_pc", address, 16'h0104);

    // R0, wraparound and ALU ops; reset out of halt clears debug state.
    reset = 1'b0;
    load(0,  enc_i(C_ADDI, 0, 0, 9));
    load(4,  enc_i(C_ADDI, 5, 5, -1));
    load(8,  enc_r(5, 0, 6, C_SLT));
    load(12, enc_r(0, 0, 7, C_ADD));
    load(16, enc_r(0, 5, 8, C_SUB));
    load(20, enc_r(5, 8, 9, C_AND));
    load(24, enc_r(8, 5, 10, C_OR));
    load(28, enc_r(0, 5, 11, C_SLT));
    load(32, enc_i(C_LW, 0, 1, 2));
    check("rec_halted", halted, 0);
    check("rec_ir", instruction, 0);
    check("rec_result", result, 0);
    check("rec_retire", retire, 0);
    check("rec_pc", address, 0);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_retire(lat);
      check($sformatf("alu_res%0d", i), result, exp5[i]);
      check($sformatf("alu_lat%0d", i), lat, 4);
    end

    // Misaligned lw halts without a data request.
    step();
    seen_req = 1'b0;
    repeat (7) begin
      step();
      seen_req = seen_req | mem_req;
    end
    check("mis_no_req", seen_req, 0);
    check("mis_halted", halted, 1);

    reset = 1'b0;
    step();
    check("mis_rst_req", mem_req, 0);
    reset = 1'b1;
    #1;
    check("mis_rel_req", mem_req, 1);
    check("mis_rel_addr", mem_addr, 0);
    check("mis_rel_halted", halted, 0);
    wait_retire(lat);
    check("mis_refetch_res", result, 9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
